// File: rtl/emesh_axi_master_write.sv
// ---------------------------------------------------------------------------
// emesh_axi_master_write
//
// AXI3-style write-channel initiator. It takes one write command plus a beat
// stream from the emesh side, issues the AW request, then forwards the beats
// on W, and collects the B response and returns it upstream as a single-cycle
// pulse. Only one transaction is in flight at a time, and AW always completes
// before the first W beat is shown.
//
// Optional feature: define EMESH_AXI_MASTER_BID_CHECK_EN to compare bid with
// the issued awid. On a mismatch a sticky id_err output is set and the
// returned response is forced to SLVERR. The id_err port exists only when the
// macro is defined.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cmd_*              write command (addr, len, size, burst, id), valid/ready
//   wr_*               upstream beat stream (data, strb), valid/ready
//   rsp_*              response pulse with latched bresp / bid
//   m_axi_aw*          AXI write address channel
//   m_axi_w*           AXI write data channel
//   m_axi_b*           AXI write response channel
//   busy               high whenever a transaction is in progress
//   id_err             sticky bid mismatch flag (optional)
// ---------------------------------------------------------------------------
module emesh_axi_master_write #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = 12,
    parameter logic [3:0]  AWCACHE = 4'b0011,
    parameter logic [2:0]  AWPROT  = 3'b000
) (
    input  logic                clk,
    input  logic                rst,

    // Command from emesh side
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    input  logic [ID_W-1:0]     cmd_id,

    // Beat stream from emesh side
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,

    // Response back to emesh side
    output logic                rsp_valid,
    output logic [1:0]          rsp_resp,
    output logic [ID_W-1:0]     rsp_id,

    // AXI write address channel
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [1:0]          m_axi_awlock,
    output logic [3:0]          m_axi_awqos,

    // AXI write data channel
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic [ID_W-1:0]     m_axi_wid,

    // AXI write response channel
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp,
    input  logic [ID_W-1:0]     m_axi_bid,

    output logic                busy
`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
    ,
    output logic                id_err
`endif
);

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_e;

    state_e              state_q,   state_d;
    logic                awvalid_q, awvalid_d;
    logic [ADDR_W-1:0]   awaddr_q,  awaddr_d;
    logic [LEN_W-1:0]    awlen_q,   awlen_d;
    logic [SIZE_W-1:0]   awsize_q,  awsize_d;
    logic [BURST_W-1:0]  awburst_q, awburst_d;
    logic [ID_W-1:0]     awid_q,    awid_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                bready_q,  bready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [RESP_W-1:0]   rsp_resp_q, rsp_resp_d;
    logic [ID_W-1:0]     rsp_id_q,  rsp_id_d;
`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
    logic                id_err_q,  id_err_d;
`endif

    logic in_w;
    logic w_hs;
    logic last_beat;

    // Decodes of the current state shared by outputs and next-state logic
    assign in_w      = (state_q == ST_W);
    assign last_beat = (beat_cnt_q == awlen_q);
    assign w_hs      = in_w && wr_valid && m_axi_wready;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            awburst_q   <= '0;
            awid_q      <= '0;
            beat_cnt_q  <= '0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_resp_q  <= '0;
            rsp_id_q    <= '0;
`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
            id_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awsize_q    <= awsize_d;
            awburst_q   <= awburst_d;
            awid_q      <= awid_d;
            beat_cnt_q  <= beat_cnt_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_id_q    <= rsp_id_d;
`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
            id_err_q    <= id_err_d;
`endif
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awsize_d    = awsize_q;
        awburst_d   = awburst_q;
        awid_d      = awid_q;
        beat_cnt_d  = beat_cnt_q;
        bready_d    = bready_q;
        rsp_valid_d = 1'b0;
        rsp_resp_d  = rsp_resp_q;
        rsp_id_d    = rsp_id_q;
`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
        id_err_d    = id_err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // Hold off a new command while the previous response pulses
                if (cmd_valid && !rsp_valid_q) begin
                    awaddr_d   = cmd_addr;
                    awlen_d    = cmd_len;
                    awsize_d   = cmd_size;
                    awburst_d  = cmd_burst;
                    awid_d     = cmd_id;
                    beat_cnt_d = '0;
                    awvalid_d  = 1'b1;
                    state_d    = ST_AW;
                end
            end

            ST_AW: begin
                if (m_axi_awready) begin
                    awvalid_d = 1'b0;
                    state_d   = ST_W;
                end
            end

            ST_W: begin
                if (w_hs) begin
                    if (last_beat) begin
                        bready_d = 1'b1;
                        state_d  = ST_B;
                    end else begin
                        // Counter stops at awlen, so 256-beat bursts never wrap
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end

            ST_B: begin
                if (m_axi_bvalid) begin
                    rsp_resp_d  = m_axi_bresp;
                    rsp_id_d    = m_axi_bid;
                    rsp_valid_d = 1'b1;
                    bready_d    = 1'b0;
                    state_d     = ST_IDLE;
`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
                    if (m_axi_bid != awid_q) begin
                        id_err_d   = 1'b1;
                        rsp_resp_d = RESP_SLVERR;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Upstream handshakes
    assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q;
    assign wr_ready  = in_w && m_axi_wready;
    assign busy      = (state_q != ST_IDLE);

    // Response outputs
    assign rsp_valid = rsp_valid_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_id    = rsp_id_q;
`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
    assign id_err    = id_err_q;
`endif

    // AW channel: registered fields, fixed attributes
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = awsize_q;
    assign m_axi_awburst = awburst_q;
    assign m_axi_awid    = awid_q;
    assign m_axi_awcache = AWCACHE;
    assign m_axi_awprot  = AWPROT;
    assign m_axi_awlock  = 2'b00;
    assign m_axi_awqos   = 4'b0000;

    // W channel: pass-through, gated so nothing shows outside the W state
    assign m_axi_wvalid = in_w && wr_valid;
    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = wr_strb;
    assign m_axi_wlast  = in_w && last_beat;
    assign m_axi_wid    = awid_q;

    // B channel
    assign m_axi_bready = bready_q;

endmodule

// File: tb/tb_emesh_axi_master_write.sv
// ---------------------------------------------------------------------------
// tb_emesh_axi_master_write
//
// Directed bench for emesh_axi_master_write. Expected AW requests, W beats and
// responses are queued as stimulus is driven; monitors on the falling edge
// pop and compare them when the DUT shows the matching handshake.
// ---------------------------------------------------------------------------
module tb_emesh_axi_master_write;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 12;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [ID_W-1:0]   id;
    } aw_exp_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
        logic [ID_W-1:0]     id;
    } w_exp_t;

    typedef struct packed {
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic                cmd_valid, cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [7:0]          cmd_len;
    logic [2:0]          cmd_size;
    logic [1:0]          cmd_burst;
    logic [ID_W-1:0]     cmd_id;
    logic                wr_valid, wr_ready;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_strb;
    logic                rsp_valid;
    logic [1:0]          rsp_resp;
    logic [ID_W-1:0]     rsp_id;
    logic                m_axi_awvalid, m_axi_awready;
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic [ID_W-1:0]     m_axi_awid;
    logic [3:0]          m_axi_awcache;
    logic [2:0]          m_axi_awprot;
    logic [1:0]          m_axi_awlock;
    logic [3:0]          m_axi_awqos;
    logic                m_axi_wvalid, m_axi_wready;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wlast;
    logic [ID_W-1:0]     m_axi_wid;
    logic                m_axi_bvalid, m_axi_bready;
    logic [1:0]          m_axi_bresp;
    logic [ID_W-1:0]     m_axi_bid;
    logic                busy;
`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
    logic                id_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int w_hs_cnt = 0;
    logic aw_done = 1'b0;

    aw_exp_t  aw_q[$];
    w_exp_t   w_q[$];
    rsp_exp_t r_q[$];

    emesh_axi_master_write dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_id(rsp_id),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awid(m_axi_awid), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awlock(m_axi_awlock), .m_axi_awqos(m_axi_awqos),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wid(m_axi_wid),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bid(m_axi_bid),
        .busy(busy)
`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
        ,
        .id_err(id_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // AW / W monitor
    always @(negedge clk) begin
        aw_exp_t a;
        w_exp_t  w;
        if (rst) begin
            aw_done = 1'b0;
        end else begin
            if (m_axi_wvalid) check("w_after_aw", 64'(aw_done), 1);
            if (m_axi_wvalid && m_axi_wready) begin
                w_hs_cnt++;
                check("w_beat_expected", 64'(w_q.size() != 0), 1);
                if (w_q.size() != 0) begin
                    w = w_q.pop_front();
                    check("wdata", 64'(m_axi_wdata), 64'(w.data));
                    check("wstrb", 64'(m_axi_wstrb), 64'(w.strb));
                    check("wlast", 64'(m_axi_wlast), 64'(w.last));
                    check("wid",   64'(m_axi_wid),   64'(w.id));
                end
            end
            if (cmd_valid && cmd_ready) aw_done = 1'b0;
            if (m_axi_awvalid && m_axi_awready) begin
                check("aw_expected", 64'(aw_q.size() != 0), 1);
                if (aw_q.size() != 0) begin
                    a = aw_q.pop_front();
                    check("awaddr",  64'(m_axi_awaddr),  64'(a.addr));
                    check("awlen",   64'(m_axi_awlen),   64'(a.len));
                    check("awsize",  64'(m_axi_awsize),  64'(a.size));
                    check("awburst", 64'(m_axi_awburst), 64'(a.burst));
                    check("awid",    64'(m_axi_awid),    64'(a.id));
                    check("awcache", 64'(m_axi_awcache), 64'h3);
                    check("awprot",  64'(m_axi_awprot),  64'h0);
                    check("awlock",  64'(m_axi_awlock),  64'h0);
                    check("awqos",   64'(m_axi_awqos),   64'h0);
                end
                aw_done = 1'b1;
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        rsp_exp_t r;
        if (!rst && rsp_valid) begin
            check("rsp_expected", 64'(r_q.size() != 0), 1);
            if (r_q.size() != 0) begin
                r = r_q.pop_front();
                check("rsp_resp", 64'(rsp_resp), 64'(r.resp));
                check("rsp_id",   64'(rsp_id),   64'(r.id));
            end
        end
    end

    task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [11:0] id);
        int cyc;
        cyc = 0;
        while (!cmd_ready && cyc < 64) begin
            step();
            cyc++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 1);
        aw_q.push_back('{addr: addr, len: len, size: size, burst: burst, id: id});
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        cmd_id    = id;
        step();
        cmd_valid = 1'b0;
        check("awvalid_1cyc", 64'(m_axi_awvalid), 1);
        check("busy_in_aw",   64'(busy), 1);
    endtask

    // Hold awready low for 'delay' cycles with a W beat already offered
    task automatic do_aw(input int delay, input logic [31:0] addr);
        wr_valid = 1'b1;
        wr_data  = 32'hBAD0BAD0;
        m_axi_wready = 1'b1;
        for (int k = 0; k < delay; k++) begin
            check("aw_hold_valid", 64'(m_axi_awvalid), 1);
            check("aw_hold_addr",  64'(m_axi_awaddr), 64'(addr));
            check("no_w_in_aw",    64'(m_axi_wvalid), 0);
            check("no_wrrdy_in_aw", 64'(wr_ready), 0);
            step();
        end
        m_axi_awready = 1'b1;
        check("aw_hold_valid", 64'(m_axi_awvalid), 1);
        check("aw_hold_addr",  64'(m_axi_awaddr), 64'(addr));
        step();
        m_axi_awready = 1'b0;
        wr_valid = 1'b0;
        m_axi_wready = 1'b0;
    endtask

    task automatic send_beats(input logic [31:0] first, input int len, input logic [11:0] id,
                              input int n, input bit toggle);
        int  sent;
        int  pushed;
        int  cyc;
        bit  ph;
        bit  hs;
        sent = 0;
        pushed = 0;
        cyc = 0;
        ph = 1'b1;
        while (sent < n && cyc < 8 * n + 32) begin
            wr_valid = 1'b1;
            wr_data  = first + 32'(sent);
            wr_strb  = 4'hF ^ 4'(sent);
            if (pushed == sent) begin
                w_q.push_back('{data: wr_data, strb: wr_strb, last: (sent == len), id: id});
                pushed++;
            end
            m_axi_wready = toggle ? ph : 1'b1;
            ph = ~ph;
            hs = m_axi_wready;
            step();
            cyc++;
            if (hs) sent++;
        end
        check("beats_sent", 64'(sent), 64'(n));
        wr_valid = 1'b0;
        m_axi_wready = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] bresp, input logic [11:0] bid, input logic [11:0] id);
        logic [1:0] exp_resp;
        exp_resp = bresp;
`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
        if (bid != id) exp_resp = 2'b10;
`endif
        check("bready_after_last", 64'(m_axi_bready), 1);
        r_q.push_back('{resp: exp_resp, id: bid});
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = bresp;
        m_axi_bid    = bid;
        step();
        m_axi_bvalid = 1'b0;
        check("rsp_pulse",          64'(rsp_valid), 1);
        check("bready_cleared",     64'(m_axi_bready), 0);
        check("cmd_ready_in_pulse", 64'(cmd_ready), 0);
        step();
        check("rsp_one_cycle",      64'(rsp_valid), 0);
        check("cmd_ready_after",    64'(cmd_ready), 1);
        check("busy_idle",          64'(busy), 0);
        check("w_queue_drained",    64'(w_q.size()), 0);
        check("rsp_queue_drained",  64'(r_q.size()), 0);
    endtask

    task automatic txn(input logic [31:0] addr, input logic [7:0] len, input logic [11:0] id,
                       input int aw_delay, input bit toggle, input logic [31:0] first,
                       input logic [1:0] bresp, input logic [11:0] bid);
        int start;
        start = w_hs_cnt;
        send_cmd(addr, len, 3'b010, 2'b01, id);
        do_aw(aw_delay, addr);
        send_beats(first, int'(len), id, int'(len) + 1, toggle);
        check("w_hs_count", 64'(w_hs_cnt - start), 64'(int'(len) + 1));
        do_b(bresp, bid, id);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        cmd_burst = '0; cmd_id = '0;
        wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = '0; m_axi_bid = '0;
        repeat (3) step();
        rst = 1'b0;
        wr_valid = 1'b1;
        m_axi_wready = 1'b1;
        step();

        // Reset state
        check("rst_awvalid",   64'(m_axi_awvalid), 0);
        check("rst_awaddr",    64'(m_axi_awaddr), 0);
        check("rst_awlen",     64'(m_axi_awlen), 0);
        check("rst_wid",       64'(m_axi_wid), 0);
        check("rst_wvalid",    64'(m_axi_wvalid), 0);
        check("rst_wr_ready",  64'(wr_ready), 0);
        check("rst_bready",    64'(m_axi_bready), 0);
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_rsp_resp",  64'(rsp_resp), 0);
        check("rst_rsp_id",    64'(rsp_id), 0);
        check("rst_busy",      64'(busy), 0);
        check("rst_cmd_ready", 64'(cmd_ready), 1);
`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
        check("rst_id_err",    64'(id_err), 0);
`endif
        wr_valid = 1'b0;
        m_axi_wready = 1'b0;

        // Single beat, immediate awready
        txn(32'h0000_1000, 8'd0, 12'h005, 0, 1'b0, 32'hDEAD_BEEF, 2'b00, 12'h005);

        // 4-beat INCR, awready delayed 3 cycles
        txn(32'h0000_2040, 8'd3, 12'h0A1, 3, 1'b0, 32'h1111_0000, 2'b00, 12'h0A1);

        // 8 beats with wready toggling
        txn(32'h0000_3000, 8'd7, 12'h123, 1, 1'b1, 32'hCAFE_0000, 2'b01, 12'h123);

        // Error response propagated verbatim
        txn(32'h0000_4000, 8'd1, 12'h007, 0, 1'b0, 32'h5555_0000, 2'b11, 12'h007);

        // Stray bvalid in IDLE is ignored
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b10;
        m_axi_bid    = 12'h0FF;
        check("stray_bready", 64'(m_axi_bready), 0);
        step();
        check("stray_no_rsp", 64'(rsp_valid), 0);
        step();
        check("stray_no_rsp2", 64'(rsp_valid), 0);
        m_axi_bvalid = 1'b0;

        // 256-beat burst
        txn(32'h0001_0000, 8'd255, 12'hFED, 0, 1'b0, 32'h0000_0000, 2'b00, 12'hFED);

        // Reset in W after two beats
        send_cmd(32'h0000_5000, 8'd3, 3'b010, 2'b01, 12'h009);
        do_aw(0, 32'h0000_5000);
        send_beats(32'h7777_0000, 3, 12'h009, 2, 1'b0);
        wr_valid = 1'b1;
        m_axi_wready = 1'b0;
        check("mid_busy", 64'(busy), 1);
        check("mid_no_bready", 64'(m_axi_bready), 0);
        w_q.delete();
        rst = 1'b1;
        step();
        check("mrst_awvalid",  64'(m_axi_awvalid), 0);
        check("mrst_wvalid",   64'(m_axi_wvalid), 0);
        check("mrst_bready",   64'(m_axi_bready), 0);
        check("mrst_rsp",      64'(rsp_valid), 0);
        check("mrst_busy",     64'(busy), 0);
        check("mrst_awaddr",   64'(m_axi_awaddr), 0);
        rst = 1'b0;
        wr_valid = 1'b0;
        step();
        check("mrst_rsp2",     64'(rsp_valid), 0);
        check("mrst_cmd_ready", 64'(cmd_ready), 1);

        // Recovery after reset
        txn(32'h0000_6000, 8'd2, 12'h00C, 2, 1'b1, 32'hABCD_0000, 2'b00, 12'h00C);

`ifdef EMESH_AXI_MASTER_BID_CHECK_EN
        check("id_err_clear", 64'(id_err), 0);
        // bid mismatch: 0x3 returned for awid 0x5
        txn(32'h0000_7000, 8'd0, 12'h005, 0, 1'b0, 32'h0BAD_0001, 2'b00, 12'h003);
        check("id_err_set", 64'(id_err), 1);
        step();
        check("id_err_sticky", 64'(id_err), 1);
`endif

        check("aw_queue_drained", 64'(aw_q.size()), 0);
        check("w_queue_final",    64'(w_q.size()), 0);
        check("rsp_queue_final",  64'(r_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/emesh_axi_master_write.md
Name: emesh_axi_master_write

Overview:
- AXI3-style write-channel initiator; the master-side counterpart of the emesh AXI slave write bridge.
- Accepts one write command (address, length, size, burst, id) plus a beat stream from the emesh side.
- Drives the AW, W and B channels and returns the write response upstream.
- Supports one outstanding transaction; AW is always issued before any W beat, matching the slave bridge's AW-then-W ordering.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- ID_W, 12, AXI ID width for awid, wid and bid.
- AWCACHE, 4'b0011, constant value driven on m_axi_awcache.
- AWPROT, 3'b000, constant value driven on m_axi_awprot.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  write command valid
- cmd_ready  out  1  command accepted (IDLE only)
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  8  beats minus 1
- cmd_size  in  3  AXI size
- cmd_burst  in  2  AXI burst
- cmd_id  in  ID_W  transaction id
- wr_valid  in  1  beat valid
- wr_ready  out  1  beat consumed
- wr_data  in  DATA_W  beat data
- wr_strb  in  DATA_W/8  byte strobes
- rsp_valid  out  1  one-cycle response pulse
- rsp_resp  out  2  latched bresp
- rsp_id  out  ID_W  latched bid
- m_axi_awvalid/awready/awaddr/awlen/awsize/awburst/awid/awcache/awprot/awlock/awqos  AXI AW; awlock=0, awqos=0
- m_axi_wvalid/wready/wdata/wstrb/wlast/wid  AXI W
- m_axi_bvalid/bready/bresp/bid  AXI B
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset is synchronous and active-high on rst; the clock is clk. On reset: state=IDLE; awvalid, wvalid, bready, rsp_valid = 0; aw* and wid registers = 0; beat_cnt = 0; rsp_resp = 0; rsp_id = 0.
- Reset mid-transaction drops all valids the next edge with no completion pulse.
- FSM states: IDLE, AW, W, B.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch addr, len, size, burst and id into aw* and wid; clear beat_cnt; awvalid=1 next cycle; go to AW.
- AW:
  - awvalid and all aw* are held stable until awready.
  - On awvalid&awready: awvalid=0; go to W next cycle.
  - No W beat is presented during AW.
- W:
  - Pass-through handshake: m_axi_wvalid = wr_valid; wr_ready = m_axi_wready; wdata and wstrb are direct.
  - wlast = (beat_cnt == awlen).
  - Each wvalid&wready increments beat_cnt (8-bit).
  - On a handshake with wlast=1: go to B and set bready=1.
  - len=0 gives a single beat with wlast on the first beat. len=255 gives 256 beats; beat_cnt never wraps inside a transaction.
- B:
  - bready=1.
  - On bvalid: latch bresp into rsp_resp and bid into rsp_id; pulse rsp_valid for exactly 1 cycle; clear bready; go to IDLE.
  - A new cmd can be accepted one cycle after the rsp_valid pulse.
- Outside the B state bready=0; a stray bvalid is ignored.
- Latency: cmd accept to awvalid = 1 cycle. AW handshake to the first possible W beat = 1 cycle. Last W beat to bready = 1 cycle. B handshake to rsp_valid = 1 cycle.
- cmd_ready=0 outside IDLE. wr_ready=0 outside W.
- Burst and size are forwarded unmodified; the block does no address arithmetic.

Optional Feature:
- Macro EMESH_AXI_MASTER_BID_CHECK_EN.
- When defined:
  - Adds output id_err (1 bit, reset 0).
  - In B, if bid != latched awid, id_err is set sticky until rst, and rsp_resp is forced to 2'b10 (SLVERR).
- When undefined:
  - The id_err port is absent.
  - rsp_resp = bresp verbatim, with no comparison logic.

Test Plan:
- Single beat: cmd addr=0x1000, len=0, id=0x5; awready immediate; one wr beat 0xDEADBEEF; bresp=0 -> awaddr=0x1000 and awlen=0; exactly 1 W beat with wlast=1 and wid=5; rsp_valid 1 cycle with rsp_id=5 and rsp_resp=0.
- 4-beat INCR with awready delayed 3 cycles -> awvalid and awaddr stable for 4 cycles; no wvalid before the AW handshake; wlast only on beat 4.
- W backpressure: wready toggles 1/0 every cycle over 8 beats -> beat order preserved; wlast on the 8th handshake only; no data lost.
- len=255 -> exactly 256 handshakes; wlast only on the last; return to IDLE after B.
- bresp=2'b11, bid=0x7 -> rsp_resp=3, rsp_id=7; cmd_ready reasserts 1 cycle after the rsp_valid pulse.
- rst asserted in the W state after beat 2 -> next cycle all valids 0, state IDLE, no rsp_valid. With BID_CHECK_EN, a bid mismatch (0x3 vs 0x5) -> id_err=1 and rsp_resp=2.
